// File: rtl/alpha_crossfade_mixer_pkg.sv
// Shared constants and types for the alpha crossfade mixer.
package alpha_pkg;

  localparam int ALPHA_W     = 5;
  localparam int ALPHA_MAX   = 16;
  localparam int ALPHA_SHIFT = 4;
  localparam int ROUND_CONST = 8;

  typedef logic [ALPHA_W-1:0] alpha_t;

  // Out-of-range weights are treated as a full switch to channel B.
  function automatic alpha_t clamp_alpha(input alpha_t a);
    return (a > alpha_t'(ALPHA_MAX)) ? alpha_t'(ALPHA_MAX) : a;
  endfunction

endpackage

// File: rtl/alpha_crossfade_mixer_if.sv
// Sample stream interface of the mixer: dual-channel input beat plus blended output beat.
interface alpha_crossfade_mixer_if #(
  parameter int DATA_W = 16
) ();
  import alpha_pkg::*;

  logic                     in_valid;
  logic signed [DATA_W-1:0] sample_a;
  logic signed [DATA_W-1:0] sample_b;
  alpha_t                   alpha_sequence;
  logic                     out_valid;
  logic signed [DATA_W-1:0] out_sample;

  modport master (
    output in_valid, sample_a, sample_b, alpha_sequence,
    input  out_valid, out_sample
  );

  modport slave (
    input  in_valid, sample_a, sample_b, alpha_sequence,
    output out_valid, out_sample
  );

endinterface

// File: rtl/alpha_crossfade_mixer_step_monitor.sv
// Watches consecutive valid (clamped) alphas and flags any jump larger than one step.
module alpha_step_monitor
  import alpha_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   in_valid,
  input  alpha_t alpha,
  input  logic   clear_errors,
  output logic   step_err
);

  alpha_t last_alpha;
  logic   have_last;
  alpha_t step_size;
  logic   step_big;

  assign step_size = (alpha > last_alpha) ? (alpha - last_alpha) : (last_alpha - alpha);
  assign step_big  = have_last && (step_size > alpha_t'(1));

  // Idle cycles leave the history untouched; a set event beats a clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_alpha <= '0;
      have_last  <= 1'b0;
      step_err   <= 1'b0;
    end else begin
      if (in_valid) begin
        last_alpha <= alpha;
        have_last  <= 1'b1;
      end
      if (in_valid && step_big) begin
        step_err <= 1'b1;
      end else if (clear_errors) begin
        step_err <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alpha_crossfade_mixer.sv
// Three-stage alpha blend of two sample channels: out = (A*(16-alpha) + B*alpha + 8) >>> 4.
// Optional alpha step monitoring is enabled with `define ALPHA_STEP_MONITOR_EN.
module alpha_crossfade_mixer
  import alpha_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  alpha_crossfade_mixer_if.slave  bus,
  input  logic                    clear_errors,
  output logic                    settled_a,
  output logic                    settled_b,
  output logic                    alpha_range_err,
  output logic                    alpha_step_err
);

  localparam int PROD_W = DATA_W + ALPHA_W;
  localparam int SUM_W  = DATA_W + ALPHA_W + 1;

  alpha_t alpha_clamped;
  logic   alpha_over;

  logic                     s1_valid;
  logic signed [DATA_W-1:0] s1_a;
  logic signed [DATA_W-1:0] s1_b;
  alpha_t                   s1_wa;
  alpha_t                   s1_wb;

  logic signed [PROD_W-1:0] a_ext, b_ext, wa_ext, wb_ext;
  logic signed [PROD_W-1:0] pa_next, pb_next;

  logic                     s2_valid;
  logic signed [PROD_W-1:0] s2_pa;
  logic signed [PROD_W-1:0] s2_pb;

  logic signed [SUM_W-1:0]  sum;
  logic signed [DATA_W-1:0] blend_next;

  assign alpha_clamped = clamp_alpha(bus.alpha_sequence);
  assign alpha_over    = bus.alpha_sequence > alpha_t'(ALPHA_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_wa    <= '0;
      s1_wb    <= '0;
    end else begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_a  <= bus.sample_a;
        s1_b  <= bus.sample_b;
        s1_wa <= alpha_t'(ALPHA_MAX) - alpha_clamped;
        s1_wb <= alpha_clamped;
      end
    end
  end

  // Weights are unsigned, so they are zero-extended before the signed multiply.
  assign a_ext   = {{ALPHA_W{s1_a[DATA_W-1]}}, s1_a};
  assign b_ext   = {{ALPHA_W{s1_b[DATA_W-1]}}, s1_b};
  assign wa_ext  = {{(PROD_W-ALPHA_W){1'b0}}, s1_wa};
  assign wb_ext  = {{(PROD_W-ALPHA_W){1'b0}}, s1_wb};
  assign pa_next = a_ext * wa_ext;
  assign pb_next = b_ext * wb_ext;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_pa    <= '0;
      s2_pb    <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_pa <= pa_next;
        s2_pb <= pb_next;
      end
    end
  end

  // Weights sum to 16, so the shifted result always fits DATA_W without saturation.
  assign sum        = SUM_W'(s2_pa) + SUM_W'(s2_pb) + SUM_W'(ROUND_CONST);
  assign blend_next = DATA_W'(sum >>> ALPHA_SHIFT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.out_valid  <= 1'b0;
      bus.out_sample <= '0;
    end else begin
      bus.out_valid <= s2_valid;
      if (s2_valid) begin
        bus.out_sample <= blend_next;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      settled_a       <= 1'b0;
      settled_b       <= 1'b0;
      alpha_range_err <= 1'b0;
    end else begin
      if (bus.in_valid) begin
        settled_a <= (alpha_clamped == '0);
        settled_b <= (alpha_clamped == alpha_t'(ALPHA_MAX));
      end
      if (bus.in_valid && alpha_over) begin
        alpha_range_err <= 1'b1;
      end else if (clear_errors) begin
        alpha_range_err <= 1'b0;
      end
    end
  end

`ifdef ALPHA_STEP_MONITOR_EN
  alpha_step_monitor u_step_monitor (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (bus.in_valid),
    .alpha        (alpha_clamped),
    .clear_errors (clear_errors),
    .step_err     (alpha_step_err)
  );
`else
  assign alpha_step_err = 1'b0;
`endif

endmodule

// File: tb/tb_alpha_crossfade_mixer.sv
// Self-checking bench for alpha_crossfade_mixer against a plain-arithmetic blend model.
module tb_alpha_crossfade_mixer;

  typedef struct {
    int due;
    int val;
  } exp_t;

  logic clk;
  logic reset;
  logic clear_errors;
  logic settled_a, settled_b, alpha_range_err, alpha_step_err;

  alpha_crossfade_mixer_if #(.DATA_W(16)) bus ();

  alpha_crossfade_mixer #(.DATA_W(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .bus             (bus),
    .clear_errors    (clear_errors),
    .settled_a       (settled_a),
    .settled_b       (settled_b),
    .alpha_range_err (alpha_range_err),
    .alpha_step_err  (alpha_step_err)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  int   ticks   = 0;
  exp_t exp_q[$];
  bit   m_seen, m_range, m_step, m_sa, m_sb;
  int   m_last;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rounded convex blend, floor((A*(16-c) + B*c + 8) / 16) with c the clamped alpha.
  function automatic int blend(input int a, input int b, input int al);
    int c, x, q;
    c = (al > 16) ? 16 : al;
    x = a * (16 - c) + b * c + 8;
    q = x / 16;
    if ((x % 16 != 0) && (x < 0)) q = q - 1;
    return q;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    ticks++;
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_seen  = 0;
    m_last  = 0;
    m_range = 0;
    m_step  = 0;
    m_sa    = 0;
    m_sb    = 0;
  endtask

  // Drives one cycle of stimulus and advances the reference model to match.
  task automatic drive_model(input bit v, input int a, input int b, input int al, input bit clr);
    int   c;
    exp_t e;
    bus.in_valid       = v;
    bus.sample_a       = 16'(a);
    bus.sample_b       = 16'(b);
    bus.alpha_sequence = 5'(al);
    clear_errors       = clr;
    c = (al > 16) ? 16 : al;
    if (v && al > 16) m_range = 1;
    else if (clr)     m_range = 0;
`ifdef ALPHA_STEP_MONITOR_EN
    if (v && m_seen && ((c - m_last > 1) || (m_last - c > 1))) m_step = 1;
    else if (clr)                                                m_step = 0;
`endif
    if (v) begin
      m_seen = 1;
      m_last = c;
      e.due  = ticks + 3;
      e.val  = blend(a, b, al);
      exp_q.push_back(e);
    end
    m_sa = m_seen && (m_last == 0);
    m_sb = m_seen && (m_last == 16);
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_model(0, 0, 0, 0, 0);
    tick();
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.out_sample !== 16'sd0) begin
      n_fail++;
      $display("[TB] FAIL reset_out got v=%b s=%0d want v=0 s=0", bus.out_valid, bus.out_sample);
    end
    n_tests++;
    if ({settled_a, settled_b, alpha_range_err, alpha_step_err} !== 4'b0000) begin
      n_fail++;
      $display("[TB] FAIL reset_flags got %b%b%b%b want 0000", settled_a, settled_b, alpha_range_err, alpha_step_err);
    end
    reset = 1'b0;
    model_reset();
    drive_model(0, 0, 0, 0, 0);
    n_tests++;
    if ({bus.out_valid, settled_a, settled_b, alpha_range_err, alpha_step_err} !== 5'b00000) begin
      n_fail++;
      $display("[TB] FAIL post_reset got v=%b flags=%b%b%b%b want all 0", bus.out_valid, settled_a, settled_b, alpha_range_err, alpha_step_err);
    end
  endtask

  task automatic test_directed_stream();
    int vec [8][4] = '{'{1, 1000, -1000, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0},
                       '{1, 1000, -1000, 16}, '{1, 100, 201, 8}, '{1, -5, 0, 3}, '{1, -32768, 32767, 0}};
    logic signed [15:0] exp_s;
    bit exp_v;
    int tmp;
    for (int i = 0; i < 14; i++) begin
      if (i < 8) drive_model(vec[i][0] != 0, vec[i][1], vec[i][2], vec[i][3], 0);
      else       drive_model(0, 0, 0, 0, 0);
      exp_v = (exp_q.size() != 0) && (exp_q[0].due == ticks);
      n_tests++;
      if (bus.out_valid !== exp_v) begin
        n_fail++;
        $display("[TB] FAIL dir_valid cyc=%0d got %b want %b", i, bus.out_valid, exp_v);
      end
      if (exp_v) begin
        tmp   = exp_q[0].val;
        exp_s = tmp[15:0];
        void'(exp_q.pop_front());
        n_tests++;
        if (bus.out_sample !== exp_s) begin
          n_fail++;
          $display("[TB] FAIL dir_sample cyc=%0d got %0d want %0d", i, bus.out_sample, exp_s);
        end
      end
      n_tests++;
      if ({settled_a, settled_b, alpha_range_err, alpha_step_err} !== {m_sa, m_sb, m_range, m_step}) begin
        n_fail++;
        $display("[TB] FAIL dir_flags cyc=%0d got %b%b%b%b want %b%b%b%b", i, settled_a, settled_b,
                 alpha_range_err, alpha_step_err, m_sa, m_sb, m_range, m_step);
      end
    end
  endtask

  task automatic test_range_error();
    int vec [10][5] = '{'{1, 0, 32767, 20, 0}, '{0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0}, '{0, 0, 0, 0, 1},
                        '{0, 0, 0, 0, 0}, '{1, 7, 9, 25, 1}, '{0, 0, 0, 0, 0}, '{1, 50, -50, 4, 0},
                        '{0, 0, 0, 0, 0}, '{0, 0, 0, 0, 1}};
    logic signed [15:0] exp_s;
    bit exp_v;
    int tmp;
    for (int i = 0; i < 14; i++) begin
      if (i < 10) drive_model(vec[i][0] != 0, vec[i][1], vec[i][2], vec[i][3], vec[i][4] != 0);
      else        drive_model(0, 0, 0, 0, 0);
      exp_v = (exp_q.size() != 0) && (exp_q[0].due == ticks);
      n_tests++;
      if (bus.out_valid !== exp_v) begin
        n_fail++;
        $display("[TB] FAIL rng_valid cyc=%0d got %b want %b", i, bus.out_valid, exp_v);
      end
      if (exp_v) begin
        tmp   = exp_q[0].val;
        exp_s = tmp[15:0];
        void'(exp_q.pop_front());
        n_tests++;
        if (bus.out_sample !== exp_s) begin
          n_fail++;
          $display("[TB] FAIL rng_sample cyc=%0d got %0d want %0d", i, bus.out_sample, exp_s);
        end
      end
      n_tests++;
      if ({settled_a, settled_b, alpha_range_err, alpha_step_err} !== {m_sa, m_sb, m_range, m_step}) begin
        n_fail++;
        $display("[TB] FAIL rng_flags cyc=%0d got %b%b%b%b want %b%b%b%b", i, settled_a, settled_b,
                 alpha_range_err, alpha_step_err, m_sa, m_sb, m_range, m_step);
      end
    end
  endtask

  task automatic test_random_stream();
    logic signed [15:0] exp_s;
    bit exp_v;
    int tmp;
    for (int i = 0; i < 260; i++) begin
      if (i < 240)
        drive_model($urandom_range(0, 9) < 7, int'($urandom_range(0, 65535)) - 32768,
                    int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 20)),
                    $urandom_range(0, 15) == 0);
      else if (exp_q.size() != 0)
        drive_model(0, 0, 0, 0, 0);
      else
        break;
      exp_v = (exp_q.size() != 0) && (exp_q[0].due == ticks);
      n_tests++;
      if (bus.out_valid !== exp_v) begin
        n_fail++;
        $display("[TB] FAIL rnd_valid cyc=%0d got %b want %b", i, bus.out_valid, exp_v);
      end
      if (exp_v) begin
        tmp   = exp_q[0].val;
        exp_s = tmp[15:0];
        void'(exp_q.pop_front());
        n_tests++;
        if (bus.out_sample !== exp_s) begin
          n_fail++;
          $display("[TB] FAIL rnd_sample cyc=%0d got %0d want %0d", i, bus.out_sample, exp_s);
        end
      end
      n_tests++;
      if ({settled_a, settled_b, alpha_range_err, alpha_step_err} !== {m_sa, m_sb, m_range, m_step}) begin
        n_fail++;
        $display("[TB] FAIL rnd_flags cyc=%0d got %b%b%b%b want %b%b%b%b", i, settled_a, settled_b,
                 alpha_range_err, alpha_step_err, m_sa, m_sb, m_range, m_step);
      end
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL rnd_drain got %0d pending want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid_pipeline();
    drive_model(1, 1234, 0, 0, 0);
    drive_model(1, 0, 4321, 20, 0);
    drive_model(1, 77, 88, 9, 0);
    drive_model(1, -300, 300, 2, 0);
    bus.in_valid = 1'b0;
    #2 reset = 1'b1;
    model_reset();
    #1;
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.out_sample !== 16'sd0) begin
      n_fail++;
      $display("[TB] FAIL mid_reset_out got v=%b s=%0d want v=0 s=0", bus.out_valid, bus.out_sample);
    end
    n_tests++;
    if ({settled_a, settled_b, alpha_range_err, alpha_step_err} !== 4'b0000) begin
      n_fail++;
      $display("[TB] FAIL mid_reset_flags got %b%b%b%b want 0000", settled_a, settled_b, alpha_range_err, alpha_step_err);
    end
    tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive_model(0, 0, 0, 0, 0);
      n_tests++;
      if ({bus.out_valid, settled_a, settled_b, alpha_range_err, alpha_step_err} !== 5'b00000) begin
        n_fail++;
        $display("[TB] FAIL post_mid_reset cyc=%0d got v=%b flags=%b%b%b%b want all 0", i, bus.out_valid,
                 settled_a, settled_b, alpha_range_err, alpha_step_err);
      end
    end
  endtask

  task automatic test_step_monitor();
    int vec [12][3] = '{'{1, 5, 0}, '{0, 0, 0}, '{1, 6, 0}, '{1, 6, 0}, '{0, 0, 0}, '{0, 0, 0},
                        '{1, 7, 0}, '{1, 9, 0}, '{0, 0, 0}, '{0, 0, 1}, '{1, 8, 0}, '{1, 2, 1}};
    logic signed [15:0] exp_s;
    bit exp_v;
    int tmp;
    for (int i = 0; i < 16; i++) begin
      if (i < 12)
        drive_model(vec[i][0] != 0, int'($urandom_range(0, 2000)) - 1000,
                    int'($urandom_range(0, 2000)) - 1000, vec[i][1], vec[i][2] != 0);
      else
        drive_model(0, 0, 0, 0, 0);
      exp_v = (exp_q.size() != 0) && (exp_q[0].due == ticks);
      n_tests++;
      if (bus.out_valid !== exp_v) begin
        n_fail++;
        $display("[TB] FAIL step_valid cyc=%0d got %b want %b", i, bus.out_valid, exp_v);
      end
      if (exp_v) begin
        tmp   = exp_q[0].val;
        exp_s = tmp[15:0];
        void'(exp_q.pop_front());
        n_tests++;
        if (bus.out_sample !== exp_s) begin
          n_fail++;
          $display("[TB] FAIL step_sample cyc=%0d got %0d want %0d", i, bus.out_sample, exp_s);
        end
      end
      n_tests++;
      if ({settled_a, settled_b, alpha_range_err, alpha_step_err} !== {m_sa, m_sb, m_range, m_step}) begin
        n_fail++;
        $display("[TB] FAIL step_flags cyc=%0d got %b%b%b%b want %b%b%b%b", i, settled_a, settled_b,
                 alpha_range_err, alpha_step_err, m_sa, m_sb, m_range, m_step);
      end
    end
  endtask

  initial begin
    reset              = 1'b1;
    clear_errors       = 1'b0;
    bus.in_valid       = 1'b0;
    bus.sample_a       = '0;
    bus.sample_b       = '0;
    bus.alpha_sequence = '0;
    model_reset();
    test_reset();
    test_directed_stream();
    test_range_error();
    test_random_stream();
    test_reset_mid_pipeline();
    test_step_monitor();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alpha_crossfade_mixer.md
Name: alpha_crossfade_mixer

Overview:
- Consumer end of the alpha sequence interface: takes the 5-bit alpha_sequence (0..16) and blends two channel sample streams into one output stream.
- Channel A is the alpha=0 channel; channel B is the alpha=16 channel.
- Output = (A*(16-alpha) + B*alpha)/16, rounded; fixed 3-cycle valid pipeline.
- Sits between the dual-channel front end and downstream decimation/output logic.

Parameters:
- DATA_W, 16, signed sample width for inputs and output.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous reset, active-high
- in_valid  input  1  sample_a/sample_b/alpha_sequence valid this cycle
- sample_a  input  DATA_W  signed sample, channel associated with alpha = 0
- sample_b  input  DATA_W  signed sample, channel associated with alpha = 16
- alpha_sequence  input  5  blend weight, legal range 0..16
- clear_errors  input  1  synchronous clear of sticky error flags
- out_valid  output  1  out_sample valid
- out_sample  output  DATA_W  blended signed sample
- settled_a  output  1  last valid alpha was 0
- settled_b  output  1  last valid alpha was 16
- alpha_range_err  output  1  sticky: alpha > 16 seen on a valid input
- alpha_step_err  output  1  sticky: |alpha step| > 1 (feature-gated)

Behaviour:
- Reset (async, active-high): every output and all pipeline registers go to 0; in-flight samples are discarded.
- After reset deassertion, flags stay low until the first valid input: settled_a=0, settled_b=0.
- No backpressure; every in_valid input produces exactly one out_valid, 3 cycles later, in order.
- Back-to-back in_valid is supported at a rate of 1 per cycle.

Pipeline stages:
- Stage 1: register samples. Clamp alpha to 16 when alpha_sequence > 16. Register wa=16-alpha and wb=alpha as unsigned 5-bit values.
- Stage 2: signed products pa=sample_a*wa and pb=sample_b*wb, each DATA_W+5 bits.
- Stage 3: sum = pa + pb + 8 (DATA_W+6 bits). out_sample = sum >>> 4 (arithmetic shift, round-half-up). The result is a convex combination, so it always fits DATA_W; no saturation.
- Valid bits shift alongside the data. When out_valid=0, out_sample holds its last value.

Status flags:
- settled_a and settled_b are registered at stage 1 on in_valid: settled_a=(clamped alpha==0), settled_b=(clamped alpha==16). Both low means a transition is in progress.
- alpha_range_err is set on a stage-1 valid with raw alpha>16. It stays set until clear_errors.
- If clear_errors and a set event occur in the same cycle, set wins.
- Reset mid-operation: pipeline is flushed, flags cleared, no spurious out_valid after release.

Optional Feature:
- Macro: ALPHA_STEP_MONITOR_EN.
- With the macro: track the last valid clamped alpha (invalid before the first valid input). If a subsequent valid alpha differs from it by more than 1, set alpha_step_err (sticky, same clear and priority rules as alpha_range_err). Idle cycles between valid inputs are ignored.
- Without the macro: alpha_step_err is tied to 0 and the monitor logic is absent.

Decomposition:
- Package alpha_pkg holds:
  - ALPHA_W=5, ALPHA_MAX=16, ALPHA_SHIFT=4, ROUND_CONST=8
  - typedef alpha_t (logic [4:0])
- One sub-module: alpha_step_monitor. It contains the last-alpha register and sticky step flag, and is instantiated only under ALPHA_STEP_MONITOR_EN.

Test Plan:
- alpha=0, A=1000, B=-1000, single in_valid -> out_valid exactly 3 cycles later, out_sample=1000, settled_a=1.
- alpha=16, A=1000, B=-1000 -> out_sample=-1000, settled_b=1.
- alpha=8, A=100, B=201 -> 151. alpha=3, A=-5, B=0 -> -4 (checks arithmetic shift and rounding). Streamed back-to-back, results appear in order, one per cycle.
- alpha=20, A=0, B=32767 -> clamped, out_sample=32767, alpha_range_err=1 and held. Assert clear_errors -> flag drops next cycle. Clear plus a new error in the same cycle -> flag stays 1.
- in_valid bursts, then reset asserted mid-pipeline -> out_valid and out_sample are 0 immediately, no out_valid after release, flags are 0.
- ALPHA_STEP_MONITOR_EN defined: valid alphas 5,6,6,7 -> no error. Then 9 -> alpha_step_err=1. Macro undefined, same stimulus -> alpha_step_err stays 0.
